board_port_arbiter: RTL and testbench

BOARD_PORT_ARBITER -- requirements
Module: board_port_arbiter

---
 rtl/project_cfg_pkg.sv | 22 ++
 rtl/board_clear_seq.sv | 43 ++++
 rtl/board_port_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_board_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/project_cfg_pkg.sv
// Project-wide board configuration: default board dimensions, the shared
// 2-bit cell type and the state encoding of the board port arbiter.
package project_cfg_pkg;

   localparam int BOARD_X_SIZE_DEF = 12;
   localparam int BOARD_Y_SIZE_DEF = 12;

   // One board cell as stored in board_mem.
   typedef logic [1:0] cell_t;

   // Value written to every cell by a board clear.
   localparam cell_t CELL_EMPTY = 2'b00;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RD_WAIT = 2'd2,
      ST_CLEAR   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/board_clear_seq.sv
// Board clear address sweep: walks x fastest, then y, over the on-board
// cells only. 'addr' is the next cell to be written, 'last' marks the
// final cell of the board.
module board_clear_seq #(
   parameter int X_SIZE = 12,
   parameter int Y_SIZE = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       step,
   output logic [7:0] addr,
   output logic       last
);

   localparam logic [3:0] X_MAX = 4'(X_SIZE - 1);
   localparam logic [3:0] Y_MAX = 4'(Y_SIZE - 1);

   logic [3:0] x_r;
   logic [3:0] y_r;

   // Coordinate counters: start rewinds to cell (0,0), step advances by one cell.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r <= 4'd0;
         y_r <= 4'd0;
      end else if (start) begin
         x_r <= 4'd0;
         y_r <= 4'd0;
      end else if (step) begin
         if (x_r == X_MAX) begin
            x_r <= 4'd0;
            y_r <= y_r + 4'd1;
         end else begin
            x_r <= x_r + 4'd1;
         end
      end
   end

   assign addr = {y_r, x_r};
   assign last = (x_r == X_MAX) && (y_r == Y_MAX);

endmodule

// File: rtl/board_port_arbiter.sv
// Board port arbiter: shares the control-side board_mem port between two
// requesters (round-robin on ties) and a board clear sweep, which has
// priority whenever the port is idle.
module board_port_arbiter
   import project_cfg_pkg::*;
#(
   parameter int BOARD_X_SIZE = BOARD_X_SIZE_DEF,
   parameter int BOARD_Y_SIZE = BOARD_Y_SIZE_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       w_nr0,
   input  logic [7:0] addr0,
   input  logic [1:0] wdata0,
   output logic       gnt0,
   output logic       rvalid0,
   output logic [1:0] rdata0,
   input  logic       req1,
   input  logic       w_nr1,
   input  logic [7:0] addr1,
   input  logic [1:0] wdata1,
   output logic       gnt1,
   output logic       rvalid1,
   output logic [1:0] rdata1,
   input  logic       clr_start,
   output logic       clr_busy,
   output logic       clr_done,
   output logic [7:0] mem_addr,
   output logic [1:0] mem_data_out,
   output logic       mem_w_nr,
   input  logic [1:0] mem_data_in
);

   arb_state_t state_r;
   logic       last_r;
   logic       owner_r;
   logic       clr_pend_r;
   logic       clr_busy_r;
   logic       clr_done_r;
   logic       clr_last_r;
   logic       gnt0_r;
   logic       gnt1_r;
   logic       rvalid0_r;
   logic       rvalid1_r;
   logic [7:0] mem_addr_r;
   cell_t      mem_data_out_r;
   logic       mem_w_nr_r;
   cell_t      rdata0_hold_r;
   cell_t      rdata1_hold_r;

   logic       sel_s;
   logic [7:0] sel_addr_s;
   logic       sel_w_nr_s;
   cell_t      sel_wdata_s;
   logic       clr_go_s;
   logic       seq_start_s;
   logic       seq_step_s;
   logic [7:0] seq_addr_s;
   logic       seq_last_s;

   board_clear_seq #(
      .X_SIZE (BOARD_X_SIZE),
      .Y_SIZE (BOARD_Y_SIZE)
   ) u_clear_seq (
      .clk   (clk),
      .rst   (rst),
      .start (seq_start_s),
      .step  (seq_step_s),
      .addr  (seq_addr_s),
      .last  (seq_last_s)
   );

   // Requester selection: the one not granted last wins a tie.
   always_comb begin
      sel_s = 1'b0;
      if (req0 && req1) begin
         sel_s = ~last_r;
      end else if (req1) begin
         sel_s = 1'b1;
      end else begin
         sel_s = 1'b0;
      end
   end

   // Route the selected requester's command towards the memory registers.
   always_comb begin
      sel_addr_s  = addr0;
      sel_w_nr_s  = w_nr0;
      sel_wdata_s = wdata0;
      if (sel_s) begin
         sel_addr_s  = addr1;
         sel_w_nr_s  = w_nr1;
         sel_wdata_s = wdata1;
      end else begin
         sel_addr_s  = addr0;
         sel_w_nr_s  = w_nr0;
         sel_wdata_s = wdata0;
      end
   end

   // Clear sweep control: rewind when a clear is launched, advance while issuing cells.
   always_comb begin
      clr_go_s    = clr_pend_r | (clr_start & ~clr_busy_r);
      seq_start_s = 1'b0;
      seq_step_s  = 1'b0;
      if (state_r == ST_IDLE) begin
         seq_start_s = clr_go_s;
      end else if (state_r == ST_CLEAR) begin
         seq_step_s = ~clr_last_r & ~seq_last_s;
      end else begin
         seq_start_s = 1'b0;
         seq_step_s  = 1'b0;
      end
   end

   // Main arbiter FSM with all handshake and memory outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         last_r         <= 1'b1;
         owner_r        <= 1'b0;
         clr_pend_r     <= 1'b0;
         clr_busy_r     <= 1'b0;
         clr_done_r     <= 1'b0;
         clr_last_r     <= 1'b0;
         gnt0_r         <= 1'b0;
         gnt1_r         <= 1'b0;
         rvalid0_r      <= 1'b0;
         rvalid1_r      <= 1'b0;
         mem_addr_r     <= 8'h00;
         mem_data_out_r <= CELL_EMPTY;
         mem_w_nr_r     <= 1'b0;
      end else begin
         gnt0_r     <= 1'b0;
         gnt1_r     <= 1'b0;
         rvalid0_r  <= 1'b0;
         rvalid1_r  <= 1'b0;
         clr_done_r <= 1'b0;

         // A clear requested mid-access is parked until the port is idle again.
         if ((state_r != ST_IDLE) && clr_start && !clr_busy_r) begin
            clr_pend_r <= 1'b1;
            clr_busy_r <= 1'b1;
         end

         case (state_r)
            ST_IDLE: begin
               mem_w_nr_r <= 1'b0;
               if (clr_go_s) begin
                  state_r    <= ST_CLEAR;
                  clr_pend_r <= 1'b0;
                  clr_busy_r <= 1'b1;
                  clr_last_r <= 1'b0;
               end else if (req0 || req1) begin
                  state_r    <= ST_ACCESS;
                  owner_r    <= sel_s;
                  last_r     <= sel_s;
                  gnt0_r     <= ~sel_s;
                  gnt1_r     <= sel_s;
                  mem_addr_r <= sel_addr_s;
                  mem_w_nr_r <= sel_w_nr_s;
                  // Write data only moves on writes so reads leave it untouched.
                  if (sel_w_nr_s) begin
                     mem_data_out_r <= sel_wdata_s;
                  end
               end
            end
            ST_ACCESS: begin
               mem_w_nr_r <= 1'b0;
               if (mem_w_nr_r) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r   <= ST_RD_WAIT;
                  rvalid0_r <= ~owner_r;
                  rvalid1_r <= owner_r;
               end
            end
            ST_RD_WAIT: begin
               mem_w_nr_r <= 1'b0;
               state_r    <= ST_IDLE;
            end
            ST_CLEAR: begin
               if (clr_last_r) begin
                  mem_w_nr_r <= 1'b0;
                  clr_done_r <= 1'b1;
                  clr_busy_r <= 1'b0;
                  clr_last_r <= 1'b0;
                  state_r    <= ST_IDLE;
               end else begin
                  mem_addr_r     <= seq_addr_s;
                  mem_data_out_r <= CELL_EMPTY;
                  mem_w_nr_r     <= 1'b1;
                  clr_last_r     <= seq_last_s;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               mem_w_nr_r <= 1'b0;
            end
         endcase
      end
   end

   // Read data holders: keep the last returned cell for each requester.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata0_hold_r <= CELL_EMPTY;
         rdata1_hold_r <= CELL_EMPTY;
      end else begin
         if (rvalid0_r) begin
            rdata0_hold_r <= mem_data_in;
         end
         if (rvalid1_r) begin
            rdata1_hold_r <= mem_data_in;
         end
      end
   end

   // Memory read data arrives in the rvalid cycle, so it is forwarded directly then.
   assign rdata0       = rvalid0_r ? mem_data_in : rdata0_hold_r;
   assign rdata1       = rvalid1_r ? mem_data_in : rdata1_hold_r;
   assign gnt0         = gnt0_r;
   assign gnt1         = gnt1_r;
   assign rvalid0      = rvalid0_r;
   assign rvalid1      = rvalid1_r;
   assign clr_busy     = clr_busy_r;
   assign clr_done     = clr_done_r;
   assign mem_addr     = mem_addr_r;
   assign mem_data_out = mem_data_out_r;
   assign mem_w_nr     = mem_w_nr_r;

endmodule

// File: tb/tb_board_port_arbiter.sv
// Directed testbench for board_port_arbiter with a synchronous-read board_mem model.
module tb_board_port_arbiter;

   logic       clk;
   logic       rst;
   logic       req0, w_nr0, req1, w_nr1;
   logic [7:0] addr0, addr1;
   logic [1:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1;
   logic [1:0] rdata0, rdata1;
   logic       clr_start, clr_busy, clr_done;
   logic [7:0] mem_addr;
   logic [1:0] mem_data_out;
   logic       mem_w_nr;
   logic [1:0] mem_data_in;

   int checks   = 0;
   int failures = 0;

   logic [1:0] tb_mem [0:255];

   board_port_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .w_nr0(w_nr0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .w_nr1(w_nr1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
      .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_w_nr(mem_w_nr),
      .mem_data_in(mem_data_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // board_mem model: write on w_nr, read data one cycle after the address.
   always @(posedge clk) begin
      if (mem_w_nr) tb_mem[mem_addr] <= mem_data_out;
      mem_data_in <= tb_mem[mem_addr];
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({gnt0, gnt1, rvalid0, rvalid1, clr_busy, clr_done, mem_w_nr} !== 7'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=0000000", {gnt0, gnt1, rvalid0, rvalid1, clr_busy, clr_done, mem_w_nr});
      end
      checks++;
      if (mem_addr !== 8'h00) begin
         failures++; $display("FAIL reset_addr got=%h exp=00", mem_addr);
      end
      checks++;
      if ({mem_data_out, rdata0, rdata1} !== 6'b0) begin
         failures++; $display("FAIL reset_data got=%b exp=000000", {mem_data_out, rdata0, rdata1});
      end
      rst = 1'b0;
   endtask

   task automatic test_write();
      logic [7:0] va [3];
      logic [1:0] vd [3];
      logic       vw [3];
      va = '{8'h35, 8'hB0, 8'hFF};
      vd = '{2'd2, 2'd3, 2'd1};
      vw = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         if (vw[i]) begin
            req1 = 1'b1; w_nr1 = 1'b1; addr1 = va[i]; wdata1 = vd[i];
         end else begin
            req0 = 1'b1; w_nr0 = 1'b1; addr0 = va[i]; wdata0 = vd[i];
         end
         @(negedge clk);
         checks++;
         if ({gnt0, gnt1} !== (vw[i] ? 2'b01 : 2'b10)) begin
            failures++; $display("FAIL write_gnt[%0d] got=%b exp=%b", i, {gnt0, gnt1}, (vw[i] ? 2'b01 : 2'b10));
         end
         checks++;
         if ({mem_addr, mem_data_out, mem_w_nr} !== {va[i], vd[i], 1'b1}) begin
            failures++; $display("FAIL write_mem[%0d] got=%h/%0d/%b exp=%h/%0d/1", i, mem_addr, mem_data_out, mem_w_nr, va[i], vd[i]);
         end
         req0 = 1'b0; req1 = 1'b0;
         @(negedge clk);
         checks++;
         if ({gnt0, gnt1, mem_w_nr} !== 3'b000 || mem_addr !== va[i] || mem_data_out !== vd[i]) begin
            failures++; $display("FAIL write_release[%0d] got=%b/%h/%0d exp=000/%h/%0d", i, {gnt0, gnt1, mem_w_nr}, mem_addr, mem_data_out, va[i], vd[i]);
         end
      end
   endtask

   task automatic test_read();
      logic [7:0] va [2];
      logic [1:0] ve [2];
      logic       vw [2];
      va = '{8'h35, 8'hB0};
      ve = '{2'd2, 2'd3};
      vw = '{1'b0, 1'b1};
      for (int i = 0; i < 2; i++) begin
         if (vw[i]) begin
            req1 = 1'b1; w_nr1 = 1'b0; addr1 = va[i];
         end else begin
            req0 = 1'b1; w_nr0 = 1'b0; addr0 = va[i];
         end
         @(negedge clk);
         checks++;
         if ({gnt0, gnt1, rvalid0, rvalid1, mem_w_nr} !== (vw[i] ? 5'b01000 : 5'b10000) || mem_addr !== va[i]) begin
            failures++; $display("FAIL read_gnt[%0d] got=%b/%h exp=%b/%h", i, {gnt0, gnt1, rvalid0, rvalid1, mem_w_nr}, mem_addr, (vw[i] ? 5'b01000 : 5'b10000), va[i]);
         end
         req0 = 1'b0; req1 = 1'b0;
         @(negedge clk);
         checks++;
         if ({gnt0, gnt1, rvalid0, rvalid1, mem_w_nr} !== (vw[i] ? 5'b00010 : 5'b00100)) begin
            failures++; $display("FAIL read_rvalid[%0d] got=%b exp=%b", i, {gnt0, gnt1, rvalid0, rvalid1, mem_w_nr}, (vw[i] ? 5'b00010 : 5'b00100));
         end
         checks++;
         if ((vw[i] ? rdata1 : rdata0) !== ve[i]) begin
            failures++; $display("FAIL read_data[%0d] got=%0d exp=%0d", i, (vw[i] ? rdata1 : rdata0), ve[i]);
         end
         @(negedge clk);
         checks++;
         if ({rvalid0, rvalid1, mem_w_nr} !== 3'b000 || (vw[i] ? rdata1 : rdata0) !== ve[i] || mem_data_out !== 2'd1) begin
            failures++; $display("FAIL read_hold[%0d] got=%b/%0d/%0d exp=000/%0d/1", i, {rvalid0, rvalid1, mem_w_nr}, (vw[i] ? rdata1 : rdata0), mem_data_out, ve[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int   n0 = 0;
      int   n1 = 0;
      int   dbl = 0;
      logic exp_id = 1'b0;
      req0 = 1'b1; w_nr0 = 1'b1; addr0 = 8'h01; wdata0 = 2'd1;
      req1 = 1'b1; w_nr1 = 1'b1; addr1 = 8'h02; wdata1 = 2'd2;
      for (int c = 0; c < 40 && (n0 < 4 || n1 < 4); c++) begin
         @(negedge clk);
         if (gnt0 && gnt1) dbl++;
         if (gnt0 || gnt1) begin
            checks++;
            if (gnt1 !== exp_id) begin
               failures++; $display("FAIL rr_order grant=%0d got_id=%b exp_id=%b", n0 + n1, gnt1, exp_id);
            end
            exp_id = ~exp_id;
            if (gnt0) n0++;
            if (gnt1) n1++;
            if (n0 >= 4) req0 = 1'b0;
            if (n1 >= 4) req1 = 1'b0;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      checks++;
      if (n0 != 4 || n1 != 4) begin
         failures++; $display("FAIL rr_count got=%0d/%0d exp=4/4", n0, n1);
      end
      checks++;
      if (dbl != 0) begin
         failures++; $display("FAIL rr_double got=%0d exp=0", dbl);
      end
      @(negedge clk);
   endtask

   task automatic test_clear();
      int         wr = 0, bad_order = 0, bad_range = 0, bad_data = 0, early_gnt = 0;
      int         done_cyc = -1, last_cyc = -1;
      logic [7:0] first_a = 8'hxx, last_a = 8'hxx;
      logic [3:0] ex = 4'd0, ey = 4'd0;
      clr_start = 1'b1;
      req0 = 1'b1; w_nr0 = 1'b1; addr0 = 8'h77; wdata0 = 2'd1;
      @(negedge clk);
      clr_start = 1'b0;
      checks++;
      if (clr_busy !== 1'b1 || gnt0 !== 1'b0) begin
         failures++; $display("FAIL clear_start got busy=%b gnt0=%b exp busy=1 gnt0=0", clr_busy, gnt0);
      end
      for (int c = 0; c < 400 && done_cyc < 0; c++) begin
         if (gnt0 || gnt1) early_gnt++;
         if (mem_w_nr) begin
            if (wr == 0) first_a = mem_addr;
            last_a = mem_addr;
            last_cyc = c;
            if (mem_addr !== {ey, ex}) bad_order++;
            if (mem_addr[3:0] >= 4'd12 || mem_addr[7:4] >= 4'd12) bad_range++;
            if (mem_data_out !== 2'b00) bad_data++;
            wr++;
            if (ex == 4'd11) begin ex = 4'd0; ey = ey + 4'd1; end
            else ex = ex + 4'd1;
         end
         if (clr_done) begin
            done_cyc = c;
            checks++;
            if (clr_busy !== 1'b0 || mem_w_nr !== 1'b0) begin
               failures++; $display("FAIL clear_done_busy got busy=%b w_nr=%b exp=0/0", clr_busy, mem_w_nr);
            end
         end else begin
            @(negedge clk);
         end
      end
      checks++;
      if (wr != 144) begin failures++; $display("FAIL clear_count got=%0d exp=144", wr); end
      checks++;
      if (first_a !== 8'h00 || last_a !== 8'hBB) begin
         failures++; $display("FAIL clear_ends got=%h..%h exp=00..bb", first_a, last_a);
      end
      checks++;
      if (bad_order != 0 || bad_range != 0 || bad_data != 0) begin
         failures++; $display("FAIL clear_sweep got order=%0d range=%0d data=%0d exp=0/0/0", bad_order, bad_range, bad_data);
      end
      checks++;
      if (done_cyc < 0 || done_cyc != last_cyc + 1) begin
         failures++; $display("FAIL clear_done_time got=%0d exp=%0d", done_cyc, last_cyc + 1);
      end
      checks++;
      if (early_gnt != 0) begin failures++; $display("FAIL clear_gnt_blocked got=%0d exp=0", early_gnt); end
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b1 || mem_addr !== 8'h77 || mem_w_nr !== 1'b1) begin
         failures++; $display("FAIL clear_then_gnt got=%b/%h/%b exp=1/77/1", gnt0, mem_addr, mem_w_nr);
      end
      req0 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_clear_during_read();
      int   wr = 0, extra = 0;
      logic pulsed = 1'b0, done = 1'b0;
      req1 = 1'b1; w_nr1 = 1'b0; addr1 = 8'h77;
      @(negedge clk);
      req1 = 1'b0;
      @(negedge clk);
      checks++;
      if (rvalid1 !== 1'b1 || rdata1 !== 2'd1 || clr_busy !== 1'b0) begin
         failures++; $display("FAIL cdr_rvalid got=%b/%0d/%b exp=1/1/0", rvalid1, rdata1, clr_busy);
      end
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      checks++;
      if (clr_busy !== 1'b1 || rvalid1 !== 1'b0 || mem_w_nr !== 1'b0) begin
         failures++; $display("FAIL cdr_latch got=%b/%b/%b exp=1/0/0", clr_busy, rvalid1, mem_w_nr);
      end
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         clr_start = 1'b0;
         if (mem_w_nr) wr++;
         if (clr_done) done = 1'b1;
         if (wr == 20 && !pulsed) begin clr_start = 1'b1; pulsed = 1'b1; end
      end
      clr_start = 1'b0;
      checks++;
      if (!done || wr != 144) begin
         failures++; $display("FAIL cdr_sweep got done=%b writes=%0d exp=1/144", done, wr);
      end
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (mem_w_nr || clr_busy || clr_done) extra++;
      end
      checks++;
      if (extra != 0) begin failures++; $display("FAIL cdr_no_resweep got=%0d exp=0", extra); end
   endtask

   task automatic test_reset_abort();
      int wr = 0, after = 0;
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      for (int c = 0; c < 300 && wr < 50; c++) begin
         @(negedge clk);
         if (mem_w_nr) wr++;
      end
      checks++;
      if (wr != 50) begin failures++; $display("FAIL abort_reach got=%0d exp=50", wr); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({mem_w_nr, clr_busy, clr_done} !== 3'b000) begin
         failures++; $display("FAIL abort_clear got=%b exp=000", {mem_w_nr, clr_busy, clr_done});
      end
      rst = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (mem_w_nr || clr_busy || clr_done) after++;
      end
      checks++;
      if (after != 0) begin failures++; $display("FAIL abort_clear_quiet got=%0d exp=0", after); end
      req0 = 1'b1; w_nr0 = 1'b0; addr0 = 8'h35;
      @(negedge clk);
      req0 = 1'b0;
      checks++;
      if (gnt0 !== 1'b1 || mem_w_nr !== 1'b0) begin
         failures++; $display("FAIL abort_read_gnt got=%b/%b exp=1/0", gnt0, mem_w_nr);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      after = 0;
      for (int c = 0; c < 10; c++) begin
         if (rvalid0 || rvalid1 || gnt0 || gnt1) after++;
         @(negedge clk);
      end
      checks++;
      if (after != 0) begin failures++; $display("FAIL abort_read_quiet got=%0d exp=0", after); end
   endtask

   initial begin
      rst = 1'b1;
      req0 = 1'b0; w_nr0 = 1'b0; addr0 = 8'h00; wdata0 = 2'd0;
      req1 = 1'b0; w_nr1 = 1'b0; addr1 = 8'h00; wdata1 = 2'd0;
      clr_start = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_clear();
      test_clear_during_read();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
